// File: rtl/reg_feed_fifo.sv
// Purpose: small FIFO feeding a data register's data_in; holds the last popped word on rd_data.
// Latency: 1 cycle from an accepted rd_en to rd_data/rd_valid; no fall-through when empty.
// Backpressure: full/empty are decoded from count; dropped writes/rejected reads set sticky flags.
module reg_feed_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              full,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_accept;
    logic              wr_accept;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign rd_accept = rd_en && !empty;
    // A pop on the same edge frees a slot, so a full FIFO can still take a write.
    assign wr_accept = wr_en && (!full || rd_accept);

    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && !wr_accept) begin
                overflow <= 1'b1;
            end
            if (rd_en && !rd_accept) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
